single_clock_fifo_ctrl: RTL and testbench

- Single-clock first-in/first-out buffer with registered read data and full/empty status.
- Reports one-cycle error pulses on overflow and underflow attempts.
- Sits between a producer and a consumer sharing one clock domain.
- Provides the same pin semantics as the codebase's FIFO interface (write enable, read enable, data in/out, full, empty, write/read error), minus the second clock/reset pair.

---
 rtl/single_clock_fifo_ctrl_if.sv | 24 ++
 rtl/single_clock_fifo_ctrl.sv | 64 ++++++
 tb/tb_single_clock_fifo_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/single_clock_fifo_ctrl_if.sv
// Producer/consumer handshake bundle for the single-clock FIFO.
// The master drives requests and write data; the slave returns data and status.
interface single_clock_fifo_ctrl_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  w_en;
   logic                  r_en;
   logic [DATA_WIDTH-1:0] data_in;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  full;
   logic                  empty;
   logic                  write_error;
   logic                  read_error;

   modport master (
      output w_en, r_en, data_in,
      input  data_out, full, empty, write_error, read_error
   );

   modport slave (
      input  w_en, r_en, data_in,
      output data_out, full, empty, write_error, read_error
   );
endinterface

// File: rtl/single_clock_fifo_ctrl.sv
// Single-clock FIFO with registered read data, full/empty status and
// one-cycle overflow/underflow error pulses.
module single_clock_fifo_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8
) (
   input  logic                     wclk,
   input  logic                     wrst_n,
   single_clock_fifo_ctrl_if.slave  bus
);
   localparam int PTR_WIDTH = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_WIDTH:0]    r_wptr;
   logic [PTR_WIDTH:0]    r_rptr;
   logic [DATA_WIDTH-1:0] r_data_out;
   logic                  r_write_error;
   logic                  r_read_error;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_wr_accept;
   logic                  w_rd_accept;

   // Pointer MSB is a wrap bit: equal low bits with differing MSBs means full.
   assign w_empty     = (r_wptr == r_rptr);
   assign w_full      = (r_wptr[PTR_WIDTH-1:0] == r_rptr[PTR_WIDTH-1:0]) &&
                        (r_wptr[PTR_WIDTH] != r_rptr[PTR_WIDTH]);
   assign w_wr_accept = bus.w_en && !w_full;
   assign w_rd_accept = bus.r_en && !w_empty;

   // Storage has no reset; the reset term only blocks writes on a reset edge.
   always_ff @(posedge wclk) begin
      if (wrst_n && w_wr_accept) begin
         r_mem[r_wptr[PTR_WIDTH-1:0]] <= bus.data_in;
      end
   end

   always_ff @(posedge wclk) begin
      if (!wrst_n) begin
         r_wptr        <= '0;
         r_rptr        <= '0;
         r_data_out    <= '0;
         r_write_error <= 1'b0;
         r_read_error  <= 1'b0;
      end else begin
         if (w_wr_accept) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_rd_accept) begin
            r_data_out <= r_mem[r_rptr[PTR_WIDTH-1:0]];
            r_rptr     <= r_rptr + 1'b1;
         end
         r_write_error <= bus.w_en && w_full;
         r_read_error  <= bus.r_en && w_empty;
      end
   end

   assign bus.data_out    = r_data_out;
   assign bus.full        = w_full;
   assign bus.empty       = w_empty;
   assign bus.write_error = r_write_error;
   assign bus.read_error  = r_read_error;
endmodule

// File: tb/tb_single_clock_fifo_ctrl.sv
// Directed bench for single_clock_fifo_ctrl: a vector table for reset, fill,
// overflow, drain and underflow, plus hand sequences for wrap and mid-run reset.
module tb_single_clock_fifo_ctrl;
   logic wclk;
   logic wrst_n;

   single_clock_fifo_ctrl_if #(.DATA_WIDTH(8)) bus ();

   single_clock_fifo_ctrl #(.DATA_WIDTH(8), .DEPTH(8)) dut (
      .wclk   (wclk),
      .wrst_n (wrst_n),
      .bus    (bus.slave)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   typedef struct {
      logic       rst_n;
      logic       w;
      logic       r;
      logic [7:0] din;
      logic [7:0] e_do;
      logic       e_full;
      logic       e_empty;
      logic       e_werr;
      logic       e_rerr;
   } vec_t;

   vec_t vecs[$];
   int   n_vec;
   int   n_fail;

   function automatic void add(input logic rst_n, input logic w, input logic r,
                               input logic [7:0] din, input logic [7:0] e_do,
                               input logic e_full, input logic e_empty,
                               input logic e_werr, input logic e_rerr);
      vec_t v;
      v.rst_n = rst_n; v.w = w; v.r = r; v.din = din; v.e_do = e_do;
      v.e_full = e_full; v.e_empty = e_empty; v.e_werr = e_werr; v.e_rerr = e_rerr;
      vecs.push_back(v);
   endfunction

   // Drive one cycle of inputs, then compare all outputs 1 time unit after the edge.
   task automatic step(input string name, input vec_t v);
      logic [11:0] act;
      logic [11:0] exp;
      wrst_n      = v.rst_n;
      bus.w_en    = v.w;
      bus.r_en    = v.r;
      bus.data_in = v.din;
      @(posedge wclk);
      #1;
      act = {bus.data_out, bus.full, bus.empty, bus.write_error, bus.read_error};
      exp = {v.e_do, v.e_full, v.e_empty, v.e_werr, v.e_rerr};
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got do=%h full=%b empty=%b werr=%b rerr=%b, want do=%h full=%b empty=%b werr=%b rerr=%b",
                  name, act[11:4], act[3], act[2], act[1], act[0],
                  exp[11:4], exp[3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic cyc(input string name, input logic rst_n, input logic w, input logic r,
                      input logic [7:0] din, input logic [7:0] e_do, input logic e_full,
                      input logic e_empty, input logic e_werr, input logic e_rerr);
      vec_t v;
      v.rst_n = rst_n; v.w = w; v.r = r; v.din = din; v.e_do = e_do;
      v.e_full = e_full; v.e_empty = e_empty; v.e_werr = e_werr; v.e_rerr = e_rerr;
      step(name, v);
   endtask

   initial begin
      logic [7:0] drain_exp [6];
      n_vec  = 0;
      n_fail = 0;
      wrst_n = 1'b1;
      bus.w_en = 1'b0;
      bus.r_en = 1'b0;
      bus.data_in = '0;

      // Reset held for two edges with both requests high.
      add(0, 1, 1, 8'h55, 8'h00, 0, 1, 0, 0);
      add(0, 1, 1, 8'h55, 8'h00, 0, 1, 0, 0);
      // Fill 0x01..0x08; full only after the 8th write.
      for (int unsigned i = 1; i <= 8; i++)
         add(1, 1, 0, 8'(i), 8'h00, (i == 8), 0, 0, 0);
      // Overflow attempt with 0xAA, then idle clears the pulse.
      add(1, 1, 0, 8'hAA, 8'h00, 1, 0, 1, 0);
      add(1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0);
      // Drain returns 0x01..0x08, never 0xAA.
      for (int unsigned i = 1; i <= 8; i++)
         add(1, 0, 1, 8'h00, 8'(i), 0, (i == 8), 0, 0);
      // Underflow held two cycles, then released.
      add(1, 0, 1, 8'h00, 8'h08, 0, 1, 0, 1);
      add(1, 0, 1, 8'h00, 8'h08, 0, 1, 0, 1);
      add(1, 0, 0, 8'h00, 8'h08, 0, 1, 0, 0);
      // Simultaneous while empty: write taken, read rejected, no bypass.
      add(1, 1, 1, 8'h77, 8'h08, 0, 0, 0, 1);
      add(1, 0, 1, 8'h00, 8'h77, 0, 1, 0, 0);

      foreach (vecs[k]) step($sformatf("vec%0d", k), vecs[k]);

      // Wrap-around: 5 in, 5 out, then 6 in so pointers cross the boundary.
      for (int unsigned i = 0; i < 5; i++)
         cyc("wrap_wr5", 1, 1, 0, 8'h30 + 8'(i), 8'h77, 0, 0, 0, 0);
      for (int unsigned i = 0; i < 5; i++)
         cyc("wrap_rd5", 1, 0, 1, 8'h00, 8'h30 + 8'(i), 0, (i == 4), 0, 0);
      for (int unsigned i = 0; i < 6; i++)
         cyc("wrap_wr6", 1, 1, 0, 8'h10 + 8'(i), 8'h34, 0, 0, 0, 0);
      for (int unsigned i = 0; i < 4; i++)
         cyc("simul", 1, 1, 1, 8'h20 + 8'(i), 8'h10 + 8'(i), 0, 0, 0, 0);
      drain_exp = '{8'h14, 8'h15, 8'h20, 8'h21, 8'h22, 8'h23};
      for (int unsigned i = 0; i < 6; i++)
         cyc("wrap_drain", 1, 0, 1, 8'h00, drain_exp[i], 0, (i == 5), 0, 0);

      // Mid-operation reset with 3 entries stored.
      for (int unsigned i = 0; i < 3; i++)
         cyc("mid_wr3", 1, 1, 0, 8'h40 + 8'(i), 8'h23, 0, 0, 0, 0);
      cyc("mid_rst", 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0);
      cyc("mid_rd_after_rst", 1, 0, 1, 8'h00, 8'h00, 0, 1, 0, 1);
      cyc("mid_idle", 1, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0);

      // Reset edge clears a pending error pulse.
      cyc("err_pend", 1, 0, 1, 8'h00, 8'h00, 0, 1, 0, 1);
      cyc("err_rst", 0, 0, 1, 8'h00, 8'h00, 0, 1, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
